car_sprite_scheduler: RTL and testbench
=======================================

Name: car_sprite_scheduler

Overview:
- Shares one car sprite memory (48x24 pixels, 1152 entries, 9-bit RGB 3:3:3, one-cycle registered read) among NUM_CARS car instances drawn on a 640x480 raster.
- Each pixel cycle it:
  - compares the current raster coordinate against every car's bounding box;
  - arbitrates overlapping cars by fixed priority;
  - issues the sprite memory address;
  - realigns the returned pixel with its hit/priority info and applies transparency.
- Car positions are written through a config port into a pending bank, which is committed at frame start so a frame never tears.

Parameters:
- NUM_CARS, 4, number of car instances sharing the sprite memory (2..8).
- IDX_W, 2, width of car index; equals clog2(NUM_CARS).
- SPRITE_W, 48, sprite width in pixels.
- SPRITE_H, 24, sprite height in pixels; SPRITE_W*SPRITE_H must be at most 2048.
- TRANSPARENT, 9'b111000111, sprite colour treated as see-through.

Ports:
- CLK  in  1  system/pixel clock.
- RST  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank; commits the pending bank.
- px_valid  in  1  raster is inside the active area this cycle.
- px_x  in  10  raster column, 0..639.
- px_y  in  10  raster row, 0..479.
- cfg_we  in  1  write strobe for one car's pending entry.
- cfg_idx  in  IDX_W  car being written.
- cfg_x  in  10  car left edge.
- cfg_y  in  10  car top edge.
- cfg_en  in  1  car visible flag.
- ram_addr  out  11  address to sprite memory (registered).
- ram_data  in  9  sprite memory read data; valid one cycle after ram_addr.
- pix_valid  out  1  opaque car pixel present.
- pix_rgb  out  9  car pixel colour; 0 when pix_valid=0.
- pix_car  out  IDX_W  index of the car supplying the pixel; 0 when pix_valid=0.

Behaviour:
- Reset:
  - All pending and active entries are cleared: x=0, y=0, en=0.
  - All pipeline valid bits are cleared.
  - ram_addr, pix_valid, pix_rgb and pix_car are 0.
  - Reset mid-frame discards in-flight pixels; outputs are 0 on the cycle after RST is sampled high.
- Config:
  - When cfg_we=1, pending[cfg_idx] <= {cfg_x, cfg_y, cfg_en}.
  - cfg_idx >= NUM_CARS is ignored.
  - Writes never affect the active bank directly.
- Commit:
  - When frame_start=1, active <= pending for all cars.
  - If cfg_we and frame_start occur in the same cycle, the commit uses the pending contents before the write. The write lands in pending and takes effect at the next frame_start.
- Hit test (stage 0, combinational on inputs), per car i:
  - hit_i = px_valid & en_i & (px_x >= x_i) & (px_x < x_i+SPRITE_W) & (px_y >= y_i) & (px_y < y_i+SPRITE_H).
  - The sums are 11-bit, so no wrap-around. A car partly beyond x=639 or y=479 is clipped naturally.
  - x_i >= 640 never hits.
- Arbitration: the lowest index with hit_i=1 wins.
- Stage 1 (register, edge 1):
  - ram_addr <= (px_y-y_w)*SPRITE_W + (px_x-x_w), where w is the winning car.
  - For the default width, the multiply is realised as (row<<5)+(row<<4).
  - Pipeline registers: hit1 <= any hit, car1 <= w.
  - With no hit, ram_addr holds its previous value and hit1=0.
- Stage 2 (edge 2): the memory returns ram_data; hit2 <= hit1, car2 <= car1.
- Stage 3 (edge 3):
  - pix_valid <= hit2 & (ram_data != TRANSPARENT).
  - pix_rgb <= ram_data if valid, else 0.
  - pix_car <= car2 if valid, else 0.
- Latency: exactly 3 cycles from px_x/px_y to pix_*. Throughput is one pixel per cycle with no stalls.
- Transparency does not pass priority down: if the winning car's texel is transparent, pix_valid=0 even if a lower-priority car overlaps.
- Active-bank changes on frame_start are seen by stage 0 from the next cycle. In-flight pixels complete with their already-computed address.

Decomposition:
- Package car_sprite_pkg holds:
  - SCREEN_W=640, SCREEN_H=480;
  - SPRITE_W, SPRITE_H, SPRITE_PIXELS=1152;
  - RGB_W=9, COORD_W=10, ADDR_W=11;
  - TRANSPARENT;
  - a car-entry struct/typedef {x, y, en}.
- One natural sub-module is car_hit_arbiter: the combinational per-car bounding-box compare plus lowest-index priority encoder, producing hit, winner index, row and column.
- The sprite memory itself stays external.

Test Plan:
- Reset: hold RST 2 cycles mid-stream with cfg_we=1 and px_valid=1 -> all outputs are 0, and no car hits after RST releases until a write plus frame_start.
- Single car: write car0 (x=100, y=200, en=1), pulse frame_start, raster (100,200) -> ram_addr=0 after 1 cycle. Raster (147,223) -> ram_addr=1151. pix_valid/pix_rgb equal the memory contents at that address, 3 cycles after input, with pix_car=0.
- Bounds: car0 at (100,200), raster (99,200), (148,200), (100,224) -> pix_valid=0 and ram_addr unchanged.
- Clipping: car at (620,470) -> hit at (639,479) with ram_addr=9*48+19=451. No hit at x=620 when y=469.
- Priority/transparency: car1 and car2 overlap at the same position -> pix_car=1. Load a TRANSPARENT texel at the overlapping address -> pix_valid=0 even though car2 hits.
- Commit timing: cfg_we for car0 x=300 in the same cycle as frame_start -> the old position stays active. The new position takes effect only after the next frame_start pulse.

Source files
------------

// File: rtl/car_sprite_scheduler_pkg.sv
// Shared constants, car entry type and sprite address helper for the car sprite scheduler.
package car_sprite_pkg;
  localparam int SCREEN_W      = 640;
  localparam int SCREEN_H      = 480;
  localparam int SPRITE_W      = 48;
  localparam int SPRITE_H      = 24;
  localparam int SPRITE_PIXELS = SPRITE_W * SPRITE_H;
  localparam int RGB_W         = 9;
  localparam int COORD_W       = 10;
  localparam int ADDR_W        = 11;

  localparam logic [RGB_W-1:0] TRANSPARENT = 9'b111000111;

  // One car's placement: left edge, top edge, visible flag.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               en;
  } car_t;
endpackage

// File: rtl/car_sprite_scheduler_if.sv
// Raster, config, sprite-memory and pixel-out signals of the scheduler.
interface car_sprite_scheduler_if #(parameter int IDX_W = 2);
  import car_sprite_pkg::*;

  logic               frame_start;
  logic               px_valid;
  logic [COORD_W-1:0] px_x;
  logic [COORD_W-1:0] px_y;
  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_idx;
  logic [COORD_W-1:0] cfg_x;
  logic [COORD_W-1:0] cfg_y;
  logic               cfg_en;
  logic [ADDR_W-1:0]  ram_addr;
  logic [RGB_W-1:0]   ram_data;
  logic               pix_valid;
  logic [RGB_W-1:0]   pix_rgb;
  logic [IDX_W-1:0]   pix_car;

  // Video timing / config / sprite memory side.
  modport master (
    output frame_start, px_valid, px_x, px_y,
    output cfg_we, cfg_idx, cfg_x, cfg_y, cfg_en,
    output ram_data,
    input  ram_addr, pix_valid, pix_rgb, pix_car
  );

  // Scheduler side.
  modport slave (
    input  frame_start, px_valid, px_x, px_y,
    input  cfg_we, cfg_idx, cfg_x, cfg_y, cfg_en,
    input  ram_data,
    output ram_addr, pix_valid, pix_rgb, pix_car
  );
endinterface

// File: rtl/car_sprite_scheduler_hit_arbiter.sv
// Per-car bounding-box compare and lowest-index-wins priority encoder.
module car_hit_arbiter
  import car_sprite_pkg::*;
#(
  parameter int NUM_CARS = 4,
  parameter int IDX_W    = 2,
  parameter int SPRITE_W = 48,
  parameter int SPRITE_H = 24
) (
  input  logic                        px_valid,
  input  logic [COORD_W-1:0]          px_x,
  input  logic [COORD_W-1:0]          px_y,
  input  car_t [NUM_CARS-1:0]         cars,
  output logic                        hit,
  output logic [IDX_W-1:0]            winner,
  output logic [ADDR_W-1:0]           row,
  output logic [ADDR_W-1:0]           col
);
  logic [NUM_CARS-1:0] hits;
  logic [ADDR_W-1:0]   rx, ry;

  assign rx = {1'b0, px_x};
  assign ry = {1'b0, px_y};

  // Right/bottom edges are summed at 11 bits so cars hanging off-screen clip instead of wrapping.
  for (genvar i = 0; i < NUM_CARS; i++) begin : g_car
    logic [ADDR_W-1:0] cx, cy;
    assign cx      = {1'b0, cars[i].x};
    assign cy      = {1'b0, cars[i].y};
    assign hits[i] = px_valid & cars[i].en
                   & (rx >= cx) & (rx < cx + ADDR_W'(SPRITE_W))
                   & (ry >= cy) & (ry < cy + ADDR_W'(SPRITE_H));
  end

  // Scan from the top index down so the lowest hitting index is the last one assigned.
  always_comb begin
    hit    = 1'b0;
    winner = '0;
    for (int i = NUM_CARS - 1; i >= 0; i--) begin
      if (hits[i]) begin
        hit    = 1'b1;
        winner = IDX_W'(i);
      end
    end
  end

  // Texel coordinates inside the winner's sprite; meaningless when hit=0.
  assign row = ry - {1'b0, cars[winner].y};
  assign col = rx - {1'b0, cars[winner].x};
endmodule

// File: rtl/car_sprite_scheduler.sv
// Shares one external car sprite memory among NUM_CARS cars: hit test, address issue, pixel realign.
module car_sprite_scheduler
  import car_sprite_pkg::*;
#(
  parameter int               NUM_CARS    = 4,
  parameter int               IDX_W       = 2,
  parameter int               SPRITE_W    = 48,
  parameter int               SPRITE_H    = 24,
  parameter logic [RGB_W-1:0] TRANSPARENT = 9'b111000111
) (
  input logic CLK,
  input logic RST,
  car_sprite_scheduler_if.slave bus
);
  car_t [NUM_CARS-1:0] pending, active;
  logic                hit0;
  logic [IDX_W-1:0]    car0, car1, car2;
  logic [ADDR_W-1:0]   row0, col0, addr0;
  logic [2:1]          vld_pipe;
  logic                opaque;

  // Config writes land only in the pending bank; out-of-range indices are dropped.
  always_ff @(posedge CLK) begin
    if (RST) pending <= '0;
    else if (bus.cfg_we && int'(bus.cfg_idx) < NUM_CARS)
      pending[bus.cfg_idx] <= '{x: bus.cfg_x, y: bus.cfg_y, en: bus.cfg_en};
  end

  // Commit at frame start takes the pre-write pending contents, so positions never tear mid-frame.
  always_ff @(posedge CLK) begin
    if (RST) active <= '0;
    else if (bus.frame_start) active <= pending;
  end

  car_hit_arbiter #(
    .NUM_CARS (NUM_CARS),
    .IDX_W    (IDX_W),
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H)
  ) u_arb (
    .px_valid (bus.px_valid),
    .px_x     (bus.px_x),
    .px_y     (bus.px_y),
    .cars     (active),
    .hit      (hit0),
    .winner   (car0),
    .row      (row0),
    .col      (col0)
  );

  // Row-major texel address; the default 48-wide sprite uses a shift-add instead of a multiplier.
  if (SPRITE_W == 48) begin : g_addr_sa
    assign addr0 = (row0 << 5) + (row0 << 4) + col0;
  end else begin : g_addr_mul
    assign addr0 = row0 * ADDR_W'(SPRITE_W) + col0;
  end

  // Stages 1-2: issue address on a hit (else hold), carry hit/car alongside the memory read.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.ram_addr <= '0;
      vld_pipe     <= '0;
      car1         <= '0;
      car2         <= '0;
    end else begin
      if (hit0) bus.ram_addr <= addr0;
      vld_pipe <= {vld_pipe[1], hit0};
      car1     <= car0;
      car2     <= car1;
    end
  end

  // A transparent winner blanks the pixel; lower-priority cars are not consulted.
  assign opaque = vld_pipe[2] && (bus.ram_data != TRANSPARENT);

  // Stage 3: register the realigned pixel, zeroing colour and car when nothing is drawn.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.pix_valid <= 1'b0;
      bus.pix_rgb   <= '0;
      bus.pix_car   <= '0;
    end else begin
      bus.pix_valid <= opaque;
      bus.pix_rgb   <= opaque ? bus.ram_data : '0;
      bus.pix_car   <= opaque ? car2 : '0;
    end
  end
endmodule

// File: tb/tb_car_sprite_scheduler.sv
// Directed bench for car_sprite_scheduler with a one-cycle registered sprite memory model.
module tb_car_sprite_scheduler;
  import car_sprite_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  car_sprite_scheduler_if #(.IDX_W(2)) bus();

  car_sprite_scheduler #(.NUM_CARS(4), .IDX_W(2)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  logic [8:0] mem [0:2047];
  int n_tests = 0;
  int n_fail  = 0;
  int last_addr = 0;

  // Texel pattern; never yields the transparent colour.
  function automatic logic [8:0] tex(int a);
    int v;
    v = (a * 37 + 11) % 512;
    if (v == 455) v = 0;
    return 9'(v);
  endfunction

  always @(posedge clk) bus.ram_data <= mem[bus.ram_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input int idx, input int x, input int y, input bit en);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_idx = 2'(idx);
    bus.cfg_x = 10'(x); bus.cfg_y = 10'(y); bus.cfg_en = en;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic commit();
    @(negedge clk); bus.frame_start = 1'b1;
    @(negedge clk); bus.frame_start = 1'b0;
  endtask

  // One isolated pixel: address one cycle later, pixel three cycles later.
  task automatic probe(input string tag, input int x, input int y, input bit hit,
                       input int addr, input int car, input logic [8:0] rgb);
    bit v;
    @(negedge clk);
    bus.px_valid = 1'b1; bus.px_x = 10'(x); bus.px_y = 10'(y);
    @(negedge clk);
    bus.px_valid = 1'b0;
    if (hit) last_addr = addr;
    chk({tag, ".addr"}, 32'(bus.ram_addr), 32'(last_addr));
    @(negedge clk);
    @(negedge clk);
    v = hit && (rgb != TRANSPARENT);
    chk({tag, ".valid"}, 32'(bus.pix_valid), 32'(v));
    chk({tag, ".rgb"},   32'(bus.pix_rgb),   v ? 32'(rgb) : 32'd0);
    chk({tag, ".car"},   32'(bus.pix_car),   v ? 32'(car) : 32'd0);
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = tex(a);
    rst = 1'b1;
    bus.frame_start = 0; bus.px_valid = 0; bus.px_x = 0; bus.px_y = 0;
    bus.cfg_we = 0; bus.cfg_idx = 0; bus.cfg_x = 0; bus.cfg_y = 0; bus.cfg_en = 0;
    repeat (3) @(negedge clk);
    chk("reset.addr",  32'(bus.ram_addr),  0);
    chk("reset.valid", 32'(bus.pix_valid), 0);
    chk("reset.rgb",   32'(bus.pix_rgb),   0);
    chk("reset.car",   32'(bus.pix_car),   0);
    rst = 1'b0;

    // Single car and its bounds.
    cfg_write(0, 100, 200, 1);
    commit();
    probe("single.first", 100, 200, 1, 0,    0, tex(0));
    probe("single.last",  147, 223, 1, 1151, 0, tex(1151));
    probe("bound.left",    99, 200, 0, 0,    0, 0);
    probe("bound.right",  148, 200, 0, 0,    0, 0);
    probe("bound.bottom", 100, 224, 0, 0,    0, 0);

    // Reset mid-stream with a write and a live pixel pending.
    @(negedge clk);
    bus.px_valid = 1; bus.px_x = 110; bus.px_y = 201;
    @(negedge clk);
    rst = 1'b1;
    bus.cfg_we = 1; bus.cfg_idx = 0; bus.cfg_x = 100; bus.cfg_y = 200; bus.cfg_en = 1;
    @(negedge clk);
    chk("midrst.addr",  32'(bus.ram_addr),  0);
    chk("midrst.valid", 32'(bus.pix_valid), 0);
    @(negedge clk);
    chk("midrst2.valid", 32'(bus.pix_valid), 0);
    chk("midrst2.rgb",   32'(bus.pix_rgb),   0);
    rst = 1'b0; bus.cfg_we = 0; bus.px_valid = 0;
    last_addr = 0;
    probe("postrst.nohit", 100, 200, 0, 0, 0, 0);
    commit();
    probe("postrst.commit", 100, 200, 0, 0, 0, 0);

    // Clipping against the screen edge.
    cfg_write(3, 620, 470, 1);
    commit();
    probe("clip.corner", 639, 479, 1, 451, 3, tex(451));
    probe("clip.above",  620, 469, 0, 0,   0, 0);
    probe("clip.origin", 620, 470, 1, 0,   3, tex(0));

    // Priority among overlapping cars, then a transparent winner texel.
    cfg_write(1, 400, 100, 1);
    cfg_write(2, 400, 100, 1);
    commit();
    probe("prio.car1", 410, 105, 1, 250, 1, tex(250));
    @(negedge clk); mem[250] = TRANSPARENT;
    probe("prio.transp", 410, 105, 1, 250, 1, TRANSPARENT);
    @(negedge clk); mem[250] = tex(250);

    // Write coinciding with frame_start lands one frame late.
    cfg_write(0, 100, 200, 1);
    commit();
    @(negedge clk);
    bus.cfg_we = 1; bus.cfg_idx = 0; bus.cfg_x = 300; bus.cfg_y = 200; bus.cfg_en = 1;
    bus.frame_start = 1;
    @(negedge clk);
    bus.cfg_we = 0; bus.frame_start = 0;
    probe("commit.old",     100, 200, 0 | 1, 0, 0, tex(0));
    probe("commit.notyet",  301, 201, 0, 0,  0, 0);
    commit();
    probe("commit.new",     301, 201, 1, 49, 0, tex(49));
    probe("commit.oldgone", 100, 200, 0, 0,  0, 0);

    // Back-to-back pixels, one per cycle.
    @(negedge clk);
    bus.px_valid = 1; bus.px_x = 302; bus.px_y = 200;
    @(negedge clk);
    bus.px_x = 303; bus.px_y = 201;
    chk("stream.addr0", 32'(bus.ram_addr), 2);
    @(negedge clk);
    bus.px_x = 304; bus.px_y = 202;
    chk("stream.addr1", 32'(bus.ram_addr), 51);
    @(negedge clk);
    bus.px_valid = 0;
    chk("stream.addr2", 32'(bus.ram_addr), 100);
    chk("stream.rgb0",  32'(bus.pix_rgb),  32'(tex(2)));
    chk("stream.vld0",  32'(bus.pix_valid), 1);
    @(negedge clk);
    chk("stream.rgb1",  32'(bus.pix_rgb),  32'(tex(51)));
    @(negedge clk);
    chk("stream.rgb2",  32'(bus.pix_rgb),  32'(tex(100)));
    @(negedge clk);
    chk("stream.idle",  32'(bus.pix_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
